// File: rtl/cpu_pkg.sv
// Shared datapath constants: result destination codes and write-back FSM states.
// Destination codes are also decoded by the ALU operand-select logic.
package cpu_pkg;

  localparam logic [1:0] DST_REGA = 2'b00;
  localparam logic [1:0] DST_REGB = 2'b01;
  localparam logic [1:0] DST_MEM  = 2'b10;
  localparam logic [1:0] DST_NONE = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_MEM_WR = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Clear/enable cycle counter; expired is asserted on the enabled edge at which the
// count would reach LIMIT, so the owner can abort on that same edge.
module wb_timeout_cnt #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign expired = en && (cnt_reg == LAST);

endmodule

// File: rtl/alu_result_writeback.sv
// ALU result write-back: routes accepted results to reg A, reg B or data memory
// (req/ack with timeout abort). Status flags are built only with ALU_WB_FLAGS_EN defined.
module alu_result_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_carry,
  input  logic [1:0]        dst_sel,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c
);

  wb_state_t state_reg, state_next;
  logic      accept;
  logic      in_mem_wr;
  logic      timeout_hit;

  assign res_ready = (state_reg == ST_IDLE);
  assign in_mem_wr = (state_reg == ST_MEM_WR);
  assign accept    = res_valid && res_ready;

  // Counting stops on an ack edge, so an ack coinciding with expiry never flags an error.
  wb_timeout_cnt #(
    .LIMIT(ACK_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!in_mem_wr),
    .en     (in_mem_wr && !mem_ack),
    .expired(timeout_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && (dst_sel == DST_MEM)) begin
          state_next = ST_MEM_WR;
        end
      end
      ST_MEM_WR: begin
        if (mem_ack || timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a     <= '0;
      reg_b     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_req   <= 1'b0;
    end else begin
      if (accept) begin
        case (dst_sel)
          DST_REGA: reg_a <= res_data;
          DST_REGB: reg_b <= res_data;
          DST_MEM: begin
            mem_addr  <= dst_addr;
            mem_wdata <= res_data;
            mem_req   <= 1'b1;
          end
          default: ;
        endcase
      end
      if (in_mem_wr && (mem_ack || timeout_hit)) begin
        mem_req <= 1'b0;
      end
    end
  end

  // A fresh abort outranks a clear arriving on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (timeout_hit) begin
      err_timeout <= 1'b1;
    end else if (err_clr) begin
      err_timeout <= 1'b0;
    end
  end

`ifdef ALU_WB_FLAGS_EN
  logic flag_z_reg, flag_n_reg, flag_c_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_reg <= 1'b0;
      flag_n_reg <= 1'b0;
      flag_c_reg <= 1'b0;
    end else if (accept) begin
      flag_z_reg <= (res_data == '0);
      flag_n_reg <= res_data[DATA_W-1];
      flag_c_reg <= res_carry;
    end
  end

  assign flag_z = flag_z_reg;
  assign flag_n = flag_n_reg;
  assign flag_c = flag_c_reg;
`else
  logic carry_unused;
  assign carry_unused = res_carry;
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_writeback.sv
// Scoreboard bench for alu_result_writeback: stimulus pushes hand-computed expectations,
// a monitor pops and compares on every accepted result; handshake timing is checked inline.
module tb_alu_result_writeback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic [1:0] dst_sel;
  logic [3:0] dst_addr;
  logic       mem_req;
  logic       mem_ack;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic       err_timeout;
  logic       err_clr;
  logic       flag_z, flag_n, flag_c;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       req;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       z, n, c;
  } exp_t;

  exp_t sb_q[$];

  alu_result_writeback #(
    .DATA_W(8), .ADDR_W(4), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .dst_sel(dst_sel), .dst_addr(dst_addr),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .reg_a(reg_a), .reg_b(reg_b), .err_timeout(err_timeout), .err_clr(err_clr),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic fexp(input logic v);
`ifdef ALU_WB_FLAGS_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // Monitor: one comparison set per accepted result, one cycle after the accepting edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n && res_valid && res_ready) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: got accept, expected none (data=%0h)", res_data);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("txn%0d_reg_a", e.id), reg_a, e.a);
          chk($sformatf("txn%0d_reg_b", e.id), reg_b, e.b);
          chk($sformatf("txn%0d_mem_req", e.id), mem_req, e.req);
          chk($sformatf("txn%0d_res_ready", e.id), res_ready, !e.req);
          if (e.req) begin
            chk($sformatf("txn%0d_mem_addr", e.id), mem_addr, e.addr);
            chk($sformatf("txn%0d_mem_wdata", e.id), mem_wdata, e.wdata);
          end
          chk($sformatf("txn%0d_flags", e.id), {flag_z, flag_n, flag_c},
              {fexp(e.z), fexp(e.n), fexp(e.c)});
          $display("txn %0d: reg_a=%0h reg_b=%0h mem_req=%0b flags=%0b%0b%0b",
                   e.id, reg_a, reg_b, mem_req, flag_z, flag_n, flag_c);
        end
      end
    end
  end

  // Issue one result; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] dst, input logic [3:0] addr, input logic [7:0] data,
                      input logic carry, input logic [7:0] ea, input logic [7:0] eb,
                      input logic ez, input logic en, input logic ec);
    exp_t e;
    int   n;
    logic done;
    e.id = txn_id; e.a = ea; e.b = eb; e.req = (dst == 2'b10);
    e.addr = addr; e.wdata = data; e.z = ez; e.n = en; e.c = ec;
    txn_id++;
    sb_q.push_back(e);
    res_valid = 1'b1; dst_sel = dst; dst_addr = addr; res_data = data; res_carry = carry;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      if (res_ready) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 50) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: got no accept in 50 cycles, expected accept");
          done = 1'b1;
        end
      end
    end
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; res_valid = 1'b0; res_data = '0; res_carry = 1'b0;
    dst_sel = 2'b00; dst_addr = '0; mem_ack = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_reg_a", reg_a, 8'h00);
    chk("rst_reg_b", reg_b, 8'h00);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_res_ready", res_ready, 1'b1);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_flags", {flag_z, flag_n, flag_c}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // Register A write.
    send(2'b00, 4'h0, 8'h3C, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);

    // Memory write acked on the third edge.
    send(2'b10, 4'h5, 8'hA5, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mw_req_held", mem_req, 1'b1);
    chk("mw_addr_held", mem_addr, 4'h5);
    chk("mw_data_held", mem_wdata, 8'hA5);
    chk("mw_ready_low", res_ready, 1'b0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("mw_req_done", mem_req, 1'b0);
    chk("mw_ready_back", res_ready, 1'b1);
    chk("mw_err", err_timeout, 1'b0);

    // Never acked: mem_req high for exactly 15 cycles, then error.
    send(2'b10, 4'h9, 8'h11, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_req_cycles", n, 15);
    chk("to_err_set", err_timeout, 1'b1);
    chk("to_ready", res_ready, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_err_clr", err_timeout, 1'b0);

    // Ack on the exact timeout edge: ack wins.
    send(2'b10, 4'h1, 8'h22, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("edge_ack_req", mem_req, 1'b0);
    chk("edge_ack_err", err_timeout, 1'b0);

    // err_clr on the same edge as a new timeout: set wins.
    send(2'b10, 4'h2, 8'h33, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_vs_set_err", err_timeout, 1'b1);
    chk("clr_vs_set_req", mem_req, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Back-to-back: reg B result held under back-pressure until the ack.
    send(2'b10, 4'h3, 8'h5A, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);
    fork
      send(2'b01, 4'h0, 8'h7F, 1'b0, 8'h3C, 8'h7F, 1'b0, 1'b0, 1'b0);
      begin
        @(negedge clk);
        chk("b2b_ready_low", res_ready, 1'b0);
        chk("b2b_reg_b_wait", reg_b, 8'h00);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
      end
    join
    chk("b2b_err", err_timeout, 1'b0);

    // Discard destination: flags only.
    send(2'b11, 4'h0, 8'h80, 1'b1, 8'h3C, 8'h7F, 1'b0, 1'b1, 1'b1);
    send(2'b11, 4'h0, 8'h00, 1'b0, 8'h3C, 8'h7F, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a memory write.
    send(2'b10, 4'h7, 8'hC3, 1'b0, 8'h3C, 8'h7F, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_regs", {reg_a, reg_b}, 16'h0000);
    chk("arst_mem_bus", {mem_addr, mem_wdata}, 12'h000);
    chk("arst_ready", res_ready, 1'b1);
    chk("arst_err_flags", {err_timeout, flag_z, flag_n, flag_c}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(2'b00, 4'h0, 8'h01, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("post_rst_err", err_timeout, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1);
  end

endmodule
